// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator and its receive checker.
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, implicit x^32 term dropped
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

  function automatic logic [31:0] galois_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  function automatic int beat_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/axis_pkt_checker.sv
// Receive-side packet length checker: counts packets and flags any packet whose TLAST
// does not land on the expected beat.
module axis_pkt_checker
  import axis_traffic_gen_pkg::*;
#(
  parameter int PKT_LEN = 4,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tvalid,
  input  logic            s_tlast,
  output logic            s_tready,
  output logic [CNTW-1:0] rx_pkt_cnt,
  output logic            rx_err
);

  localparam int BEATW = beat_w(PKT_LEN);
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(PKT_LEN - 1);

  logic [BEATW-1:0] beat_r;
  logic [CNTW-1:0]  cnt_r;
  logic             tready_r;
  logic             err_r;
  logic             hs_s;
  logic             at_end_s;

  assign hs_s     = s_tvalid & tready_r;
  assign at_end_s = (beat_r == LAST_BEAT);

  // Beat tracking, saturating packet count and sticky length error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_r <= 1'b0;
      beat_r   <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      tready_r <= 1'b1;
      if (hs_s) begin
        if (s_tlast) begin
          beat_r <= '0;
          if (cnt_r != {CNTW{1'b1}}) cnt_r <= cnt_r + CNTW'(1);
          if (!at_end_s) err_r <= 1'b1;
        end else if (at_end_s) begin
          // missing TLAST: resynchronise on the next beat
          beat_r <= '0;
          err_r  <= 1'b1;
        end else begin
          beat_r <= beat_r + BEATW'(1);
        end
      end
    end
  end

  assign s_tready   = tready_r;
  assign rx_pkt_cnt = cnt_r;
  assign rx_err     = err_r;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream mesh traffic generator: sends NUM_PKTS LFSR-filled packets per START,
// rotating destination around the mesh, while checking packet lengths on the receive side.
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int                 TDATAW       = 32,
  parameter int                 TDESTW       = 4,
  parameter int                 LFSR_DW      = 32,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = LFSR_DW'(32'hACE1_ACE1),
  parameter int                 PKT_LEN      = 4,
  parameter int                 NUM_PKTS     = 8,
  parameter int                 NUM_DEST     = 4,
  parameter int                 SELF_DEST    = 0,
  parameter int                 CNTW         = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNTW-1:0]   TX_PKT_CNT,
  output logic [CNTW-1:0]   RX_PKT_CNT,
  output logic              RX_ERR
);

  localparam int BEATW = beat_w(PKT_LEN);
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(PKT_LEN - 1);
  localparam logic [CNTW-1:0]  LAST_PKT  = CNTW'(NUM_PKTS - 1);
  localparam int FIRST_DEST_I = (NUM_DEST > 1) ? (SELF_DEST + 1) % NUM_DEST : SELF_DEST;
  localparam logic [TDESTW-1:0] FIRST_DEST = TDESTW'(FIRST_DEST_I);

  // Next endpoint in the ring, stepping over our own id
  function automatic logic [TDESTW-1:0] dest_after(input logic [TDESTW-1:0] d);
    int n;
    n = (int'(d) + 1) % NUM_DEST;
    if (NUM_DEST > 1 && n == SELF_DEST) n = (n + 1) % NUM_DEST;
    if (NUM_DEST == 1) n = SELF_DEST;
    return TDESTW'(n);
  endfunction

  state_e              state_r, state_nxt_s;
  logic                enter_send_s, m_hs_s, final_beat_s;
  logic                tvalid_r, busy_r, done_r, tlast_r;
  logic [LFSR_DW-1:0]  lfsr_r, lfsr_nxt_s;
  logic [BEATW-1:0]    beat_r;
  logic [TDESTW-1:0]   dest_r;
  logic [CNTW-1:0]     tx_cnt_r;
  logic                unused_s;

  assign m_hs_s       = tvalid_r & AXIS_M_TREADY;
  assign final_beat_s = m_hs_s & tlast_r & (tx_cnt_r == LAST_PKT);
  assign lfsr_nxt_s   = LFSR_DW'(galois_step(32'(lfsr_r)));
  assign unused_s     = ^{AXIS_S_TDATA, AXIS_S_TDEST};

  // Next-state decode
  always_comb begin
    state_nxt_s  = state_r;
    enter_send_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (START) begin
          state_nxt_s  = ST_SEND;
          enter_send_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SEND: begin
        if (final_beat_s) state_nxt_s = ST_FINISH;
        else              state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      tvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      tvalid_r <= (state_nxt_s == ST_SEND);
      busy_r   <= (state_nxt_s == ST_SEND);
      done_r   <= (state_nxt_s == ST_FINISH);
    end
  end

  // Transmit datapath: only moves on a handshake, so a stall holds every output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_r   <= LFSR_DEFAULT;
      beat_r   <= '0;
      tlast_r  <= 1'b0;
      dest_r   <= '0;
      tx_cnt_r <= '0;
    end else if (enter_send_s) begin
      beat_r   <= '0;
      tlast_r  <= (PKT_LEN == 1);
      dest_r   <= FIRST_DEST;
      tx_cnt_r <= '0;
    end else if (m_hs_s) begin
      lfsr_r <= lfsr_nxt_s;
      if (tlast_r) begin
        beat_r   <= '0;
        tlast_r  <= (PKT_LEN == 1);
        dest_r   <= dest_after(dest_r);
        tx_cnt_r <= tx_cnt_r + CNTW'(1);
      end else begin
        beat_r  <= beat_r + BEATW'(1);
        tlast_r <= ((beat_r + BEATW'(1)) == LAST_BEAT);
      end
    end
  end

  axis_pkt_checker #(
    .PKT_LEN (PKT_LEN),
    .CNTW    (CNTW)
  ) u_pkt_checker (
    .clk        (CLK),
    .rst_n      (RST_N),
    .s_tvalid   (AXIS_S_TVALID),
    .s_tlast    (AXIS_S_TLAST),
    .s_tready   (AXIS_S_TREADY),
    .rx_pkt_cnt (RX_PKT_CNT),
    .rx_err     (RX_ERR)
  );

  assign AXIS_M_TVALID = tvalid_r;
  assign AXIS_M_TDATA  = lfsr_r[TDATAW-1:0];
  assign AXIS_M_TLAST  = tlast_r;
  assign AXIS_M_TDEST  = dest_r;
  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign TX_PKT_CNT    = tx_cnt_r;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: expected beat stream built from a queue model.
module tb_axis_traffic_gen;

  localparam int TDATAW = 32, TDESTW = 4, PKT_LEN = 4, NUM_PKTS = 8;
  localparam int NUM_DEST = 4, SELF_DEST = 0, CNTW = 16;
  localparam logic [31:0] SEED = 32'hACE1_ACE1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, loop_en = 1'b0;
  logic m_tready_drv = 1'b1, s_tvalid_drv = 1'b0, s_tlast_drv = 1'b0;
  logic [TDATAW-1:0] s_tdata_drv = '0;
  logic m_tvalid, m_tready, m_tlast, s_tvalid, s_tready, s_tlast;
  logic [TDATAW-1:0] m_tdata, s_tdata;
  logic [TDESTW-1:0] m_tdest, s_tdest;
  logic busy, done, rx_err;
  logic [CNTW-1:0] tx_cnt, rx_cnt;

  assign m_tready = loop_en ? s_tready : m_tready_drv;
  assign s_tvalid = loop_en ? m_tvalid : s_tvalid_drv;
  assign s_tlast  = loop_en ? m_tlast  : s_tlast_drv;
  assign s_tdata  = loop_en ? m_tdata  : s_tdata_drv;
  assign s_tdest  = loop_en ? m_tdest  : 4'd0;

  axis_traffic_gen dut (
    .CLK(clk), .RST_N(rst_n), .START(start),
    .AXIS_M_TVALID(m_tvalid), .AXIS_M_TREADY(m_tready), .AXIS_M_TDATA(m_tdata),
    .AXIS_M_TLAST(m_tlast), .AXIS_M_TDEST(m_tdest),
    .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready), .AXIS_S_TDATA(s_tdata),
    .AXIS_S_TLAST(s_tlast), .AXIS_S_TDEST(s_tdest),
    .BUSY(busy), .DONE(done), .TX_PKT_CNT(tx_cnt), .RX_PKT_CNT(rx_cnt), .RX_ERR(rx_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int rdy_mode = 0, pat_idx = 0, run_beats = 0;
  logic [31:0] model_lfsr = SEED;
  logic [36:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Multiply by x modulo x^32+x^22+x^2+x+1
  function automatic logic [31:0] gal(input logic [31:0] x);
    logic [31:0] y;
    y = x << 1;
    if (x[31]) y = y ^ 32'h0040_0007;
    return y;
  endfunction

  // Endpoint ring excluding ourselves, starting just after our own id
  function automatic logic [3:0] dest_of(input int p);
    int ids[$];
    if (NUM_DEST == 1) return 4'(SELF_DEST);
    for (int k = 1; k < NUM_DEST; k++) ids.push_back((SELF_DEST + k) % NUM_DEST);
    return 4'(ids[p % ids.size()]);
  endfunction

  task automatic queue_run();
    for (int p = 0; p < NUM_PKTS; p++)
      for (int b = 0; b < PKT_LEN; b++) begin
        exp_q.push_back({dest_of(p), (b == PKT_LEN - 1) ? 1'b1 : 1'b0, model_lfsr});
        model_lfsr = gal(model_lfsr);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_and_wait(input string tag);
    int n;
    queue_run();
    run_beats = 0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      cyc(1);
      n++;
    end
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_txcnt"}, tx_cnt, NUM_PKTS);
    check_val({tag, "_beats"}, run_beats, NUM_PKTS * PKT_LEN);
    check_val({tag, "_qleft"}, exp_q.size(), 0);
  endtask

  task automatic send_s_pkt(input int len, input int last_idx);
    for (int b = 0; b < len; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        s_tvalid_drv = 1'b0;
        cyc(1);
      end
      s_tvalid_drv = 1'b1;
      s_tlast_drv  = (b == last_idx);
      s_tdata_drv  = $urandom;
      cyc(1);
    end
    s_tvalid_drv = 1'b0;
    s_tlast_drv  = 1'b0;
  endtask

  // Transmit-side TREADY patterns
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready_drv = 1'b1;
      1:       m_tready_drv = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
      default: m_tready_drv = 1'($urandom_range(0, 1));
    endcase
    pat_idx++;
  end

  // Beat monitor and stall-stability check, sampled on the falling edge
  initial begin
    logic [36:0] held, e;
    bit stall_pend;
    stall_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          check_val("stall_tvalid", m_tvalid, 1);
          check_val("stall_beat", {m_tdest, m_tlast, m_tdata}, held);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("tdata", m_tdata, e[31:0]);
            check_val("tlast", m_tlast, e[32]);
            check_val("tdest", m_tdest, e[36:33]);
          end
          run_beats++;
        end
        stall_pend = m_tvalid && !m_tready;
        held = {m_tdest, m_tlast, m_tdata};
      end
    end
  end

  initial begin
    int n;
    #12;
    check_val("rst_tvalid", m_tvalid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_txcnt", tx_cnt, 0);
    check_val("rst_rxcnt", rx_cnt, 0);
    check_val("rst_rxerr", rx_err, 0);
    check_val("rst_stready", s_tready, 0);
    check_val("rst_tlast", m_tlast, 0);
    check_val("rst_tdest", m_tdest, 0);
    check_val("rst_tdata", m_tdata, SEED);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3);
    check_val("stready_up", s_tready, 1);
    check_val("idle_tvalid", m_tvalid, 0);

    rdy_mode = 0; run_and_wait("runA");
    rdy_mode = 1; run_and_wait("runB");
    rdy_mode = 2; run_and_wait("runC");
    rdy_mode = 0;

    repeat (3) send_s_pkt(PKT_LEN, PKT_LEN - 1);
    check_val("rx_good_cnt", rx_cnt, 3);
    check_val("rx_good_err", rx_err, 0);
    send_s_pkt(3, 2);
    check_val("rx_short_err", rx_err, 1);
    check_val("rx_short_cnt", rx_cnt, 4);
    repeat (2) send_s_pkt(PKT_LEN, PKT_LEN - 1);
    check_val("rx_err_sticky", rx_err, 1);
    check_val("rx_after_cnt", rx_cnt, 6);

    // Reset in the middle of a run
    queue_run();
    run_beats = 0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    n = 0;
    while (run_beats < 5 && n < 200) begin
      cyc(1);
      n++;
    end
    check_val("midrun_reached", run_beats >= 5, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_lfsr = SEED;
    #1;
    check_val("mid_rst_tvalid", m_tvalid, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_txcnt", tx_cnt, 0);
    check_val("mid_rst_rxcnt", rx_cnt, 0);
    check_val("mid_rst_rxerr", rx_err, 0);
    check_val("mid_rst_tdest", m_tdest, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(10);
    check_val("post_rst_tvalid", m_tvalid, 0);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_done", done, 0);

    // Loopback over two runs; model LFSR is not reseeded between them
    loop_en = 1'b1;
    run_and_wait("loop1");
    run_and_wait("loop2");
    cyc(2);
    check_val("loop_rxcnt", rx_cnt, 2 * NUM_PKTS);
    check_val("loop_rxerr", rx_err, 0);
    loop_en = 1'b0;

    // Final beat of a packet arriving without TLAST
    send_s_pkt(PKT_LEN, -1);
    check_val("notlast_err", rx_err, 1);
    check_val("notlast_cnt", rx_cnt, 2 * NUM_PKTS);
    send_s_pkt(PKT_LEN, PKT_LEN - 1);
    check_val("resync_cnt", rx_cnt, 2 * NUM_PKTS + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
